// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage pipeline.
// Tracks the register writers in EX/ME/WB and tells decode where each source operand comes from.
// It also tells decode when it must stall because an operand is not yet available.
module hazard_scoreboard #(
  parameter int unsigned AW       = 5,
  parameter int unsigned LD_LATCH = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_src1,
  input  logic          id_src1_use,
  input  logic [AW-1:0] id_src2,
  input  logic          id_src2_use,
  input  logic [AW-1:0] id_dest,
  input  logic          id_gr_we,
  input  logic          id_is_load,
  input  logic          id_fire,
  input  logic          ex_fire,
  input  logic          me_fire,
  input  logic          wb_retire,
  input  logic          me_ld_data_ok,
  input  logic          flush,
  output logic          stall,
  output logic [1:0]    fwd_sel1,
  output logic [1:0]    fwd_sel2,
  output logic [1:0]    inflight_cnt
);

  // Forwarding source codes
  localparam logic [1:0] SelRf = 2'd0;
  localparam logic [1:0] SelEx = 2'd1;
  localparam logic [1:0] SelMe = 2'd2;
  localparam logic [1:0] SelWb = 2'd3;

  // EX slot. Its rdy bit is always 0, so it is not stored.
  logic          ex_v_q, ex_v_d;
  logic [AW-1:0] ex_dest_q, ex_dest_d;
  logic          ex_we_q, ex_we_d;
  logic          ex_ld_q, ex_ld_d;

  // ME slot
  logic          me_v_q, me_v_d;
  logic [AW-1:0] me_dest_q, me_dest_d;
  logic          me_we_q, me_we_d;
  logic          me_ld_q, me_ld_d;
  logic          me_rdy_q, me_rdy_d;

  // WB slot. It is always available, so its ld and rdy bits are not needed.
  logic          wb_v_q, wb_v_d;
  logic [AW-1:0] wb_dest_q, wb_dest_d;
  logic          wb_we_q, wb_we_d;

  // Per-slot hit vectors, bit 0 = EX, bit 1 = ME, bit 2 = WB
  logic [2:0] hit1, hit2;
  logic [2:0] avail;
  logic       miss1, miss2;

  // Returns 1 when a valid writer slot produces the register that is read
  function automatic logic slot_match(input logic          v,
                                      input logic          we,
                                      input logic [AW-1:0] dest,
                                      input logic [AW-1:0] src,
                                      input logic          src_use);
    return v & we & src_use & (src != '0) & (dest == src);
  endfunction

  // Picks the youngest hit and reports whether that slot's value is not ready yet.
  // An older, available hit must not hide an unavailable younger one.
  function automatic logic [2:0] pick(input logic [2:0] hit, input logic [2:0] av);
    logic [2:0] res;
    res = {1'b0, SelRf};
    if (hit[0]) begin
      res = {~av[0], SelEx};
    end else if (hit[1]) begin
      res = {~av[1], SelMe};
    end else if (hit[2]) begin
      res = {~av[2], SelWb};
    end
    return res;
  endfunction

  // EX slot next state. A flush wins over an issue from decode.
  always_comb begin
    ex_v_d    = ex_v_q;
    ex_dest_d = ex_dest_q;
    ex_we_d   = ex_we_q;
    ex_ld_d   = ex_ld_q;
    if (id_fire) begin
      ex_v_d    = 1'b1;
      ex_dest_d = id_dest;
      ex_we_d   = id_gr_we & (id_dest != '0);
      ex_ld_d   = id_is_load;
    end else if (ex_fire) begin
      ex_v_d = 1'b0;
    end
    if (flush) begin
      ex_v_d = 1'b0;
    end
  end

  // ME slot next state. rdy remembers that load data already returned while the load waits in ME.
  always_comb begin
    me_v_d    = me_v_q;
    me_dest_d = me_dest_q;
    me_we_d   = me_we_q;
    me_ld_d   = me_ld_q;
    me_rdy_d  = me_rdy_q;
    if (ex_fire) begin
      me_v_d    = ex_v_q;
      me_dest_d = ex_dest_q;
      me_we_d   = ex_we_q;
      me_ld_d   = ex_ld_q;
      me_rdy_d  = 1'b0;
    end else if (me_fire) begin
      me_v_d   = 1'b0;
      me_rdy_d = 1'b0;
    end else if ((LD_LATCH != 0) && me_v_q && me_ld_q && me_ld_data_ok) begin
      me_rdy_d = 1'b1;
    end
    if (flush) begin
      me_v_d   = 1'b0;
      me_rdy_d = 1'b0;
    end
  end

  // WB slot next state. A flush does not affect WB.
  always_comb begin
    wb_v_d    = wb_v_q;
    wb_dest_d = wb_dest_q;
    wb_we_d   = wb_we_q;
    if (me_fire) begin
      wb_v_d    = me_v_q;
      wb_dest_d = me_dest_q;
      wb_we_d   = me_we_q;
    end else if (wb_retire) begin
      wb_v_d = 1'b0;
    end
  end

  // Slot registers, cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v_q    <= 1'b0;
      ex_dest_q <= '0;
      ex_we_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      me_v_q    <= 1'b0;
      me_dest_q <= '0;
      me_we_q   <= 1'b0;
      me_ld_q   <= 1'b0;
      me_rdy_q  <= 1'b0;
      wb_v_q    <= 1'b0;
      wb_dest_q <= '0;
      wb_we_q   <= 1'b0;
    end else begin
      ex_v_q    <= ex_v_d;
      ex_dest_q <= ex_dest_d;
      ex_we_q   <= ex_we_d;
      ex_ld_q   <= ex_ld_d;
      me_v_q    <= me_v_d;
      me_dest_q <= me_dest_d;
      me_we_q   <= me_we_d;
      me_ld_q   <= me_ld_d;
      me_rdy_q  <= me_rdy_d;
      wb_v_q    <= wb_v_d;
      wb_dest_q <= wb_dest_d;
      wb_we_q   <= wb_we_d;
    end
  end

  // Operand lookup and stall, combinational from slot state and live inputs
  always_comb begin
    avail = {1'b1, (~me_ld_q | me_rdy_q | me_ld_data_ok), ~ex_ld_q};
    hit1  = {slot_match(wb_v_q, wb_we_q, wb_dest_q, id_src1, id_src1_use),
             slot_match(me_v_q, me_we_q, me_dest_q, id_src1, id_src1_use),
             slot_match(ex_v_q, ex_we_q, ex_dest_q, id_src1, id_src1_use)};
    hit2  = {slot_match(wb_v_q, wb_we_q, wb_dest_q, id_src2, id_src2_use),
             slot_match(me_v_q, me_we_q, me_dest_q, id_src2, id_src2_use),
             slot_match(ex_v_q, ex_we_q, ex_dest_q, id_src2, id_src2_use)};
    {miss1, fwd_sel1} = pick(hit1, avail);
    {miss2, fwd_sel2} = pick(hit2, avail);
    stall = id_valid & (miss1 | miss2);
  end

  // Occupancy count. WB counts only while it still has a register write pending.
  always_comb begin
    inflight_cnt = {1'b0, ex_v_q} + {1'b0, me_v_q} + {1'b0, wb_v_q & wb_we_q};
  end

  // Handshake protocol checks
  a_no_issue_on_stall: assert property (@(posedge clk) disable iff (reset) !(id_fire && stall));
  a_ex_fire_valid:     assert property (@(posedge clk) disable iff (reset) !(ex_fire && !ex_v_q));
  a_me_fire_valid:     assert property (@(posedge clk) disable iff (reset) !(me_fire && !me_v_q));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard. It runs directed scenarios and then legal random traffic.
// All results are compared against a pipeline model that lives in the bench.
module tb_hazard_scoreboard;

  localparam int unsigned LdLatch = 1;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_src1, id_src2, id_dest;
  logic       id_src1_use, id_src2_use, id_gr_we, id_is_load;
  logic       id_fire, ex_fire, me_fire, wb_retire, me_ld_data_ok, flush;
  logic       stall;
  logic [1:0] fwd_sel1, fwd_sel2, inflight_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model pipeline: index 0 = EX, 1 = ME, 2 = WB
  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       we;
    logic       ld;
    logic       rdy;
  } mslot_t;
  mslot_t m [3];

  hazard_scoreboard #(
    .AW       (5),
    .LD_LATCH (LdLatch)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_src1       (id_src1),
    .id_src1_use   (id_src1_use),
    .id_src2       (id_src2),
    .id_src2_use   (id_src2_use),
    .id_dest       (id_dest),
    .id_gr_we      (id_gr_we),
    .id_is_load    (id_is_load),
    .id_fire       (id_fire),
    .ex_fire       (ex_fire),
    .me_fire       (me_fire),
    .wb_retire     (wb_retire),
    .me_ld_data_ok (me_ld_data_ok),
    .flush         (flush),
    .stall         (stall),
    .fwd_sel1      (fwd_sel1),
    .fwd_sel2      (fwd_sel2),
    .inflight_cnt  (inflight_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Scans youngest to oldest and reports the first writer of src and whether it stalls.
  function automatic void find_src(input logic [4:0] src, input logic use_it,
                                   output logic [1:0] sel, output logic miss);
    sel  = 2'd0;
    miss = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (sel == 2'd0 && use_it && src != 5'd0 && m[k].v && m[k].we && m[k].dest == src) begin
        sel = 2'(k + 1);
        if (k == 0)      miss = m[k].ld;
        else if (k == 1) miss = m[k].ld && !m[k].rdy && !me_ld_data_ok;
        else             miss = 1'b0;
      end
    end
  endfunction

  function automatic logic model_stall();
    logic [1:0] s1, s2;
    logic       x1, x2;
    find_src(id_src1, id_src1_use, s1, x1);
    find_src(id_src2, id_src2_use, s2, x2);
    return id_valid && (x1 || x2);
  endfunction

  // Compares all outputs against the model, away from the clock edge
  task automatic sample();
    logic [1:0] s1, s2, cnt;
    logic       x1, x2;
    @(negedge clk);
    find_src(id_src1, id_src1_use, s1, x1);
    find_src(id_src2, id_src2_use, s2, x2);
    cnt = 2'(int'(m[0].v) + int'(m[1].v) + int'(m[2].v && m[2].we));
    check("stall", 4'(stall), 4'(model_stall()));
    check("fwd_sel1", 4'(fwd_sel1), 4'(s1));
    check("fwd_sel2", 4'(fwd_sel2), 4'(s2));
    check("inflight_cnt", 4'(inflight_cnt), 4'(cnt));
  endtask

  // Advances the model by one clock and waits past the DUT edge
  task automatic tick();
    mslot_t n [3];
    n = m;
    if (reset) begin
      for (int k = 0; k < 3; k++) n[k] = '0;
    end else begin
      if (me_fire) n[2] = m[1];
      else if (wb_retire) n[2].v = 1'b0;
      if (ex_fire) begin
        n[1] = m[0];
        n[1].rdy = 1'b0;
      end else if (me_fire) n[1].v = 1'b0;
      else if (LdLatch != 0 && m[1].v && m[1].ld && me_ld_data_ok) n[1].rdy = 1'b1;
      if (id_fire) n[0] = '{1'b1, id_dest, id_gr_we && id_dest != 5'd0, id_is_load, 1'b0};
      else if (ex_fire) n[0].v = 1'b0;
      if (flush) begin
        n[0].v = 1'b0;
        n[1].v = 1'b0;
      end
    end
    m = n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; id_valid = 0; id_src1 = 0; id_src1_use = 0; id_src2 = 0; id_src2_use = 0;
    id_dest = 0; id_gr_we = 0; id_is_load = 0; id_fire = 0; ex_fire = 0; me_fire = 0;
    wb_retire = 0; me_ld_data_ok = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] dest, input logic we, input logic ld);
    id_valid = 1; id_fire = 1; id_dest = dest; id_gr_we = we; id_is_load = ld;
  endtask

  task automatic read(input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2);
    id_valid = 1; id_src1 = s1; id_src1_use = u1; id_src2 = s2; id_src2_use = u2;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) m[k] = '0;
    idle();
    do_reset();
    do_reset();

    // Reset state
    sample();
    check("rst_stall", 4'(stall), 4'd0);
    check("rst_cnt", 4'(inflight_cnt), 4'd0);
    tick();

    // T1: ALU result forwarded from EX
    idle(); issue(5'd5, 1, 0); sample(); tick();
    idle(); read(5'd5, 1, 5'd0, 0); sample();
    check("t1_sel1", 4'(fwd_sel1), 4'd1);
    check("t1_stall", 4'(stall), 4'd0);
    tick();

    // T2: load-use stall until data returns, then latched readiness
    do_reset();
    idle(); issue(5'd7, 1, 1); sample(); tick();
    idle(); read(5'd0, 0, 5'd7, 1); sample();
    check("t2_stall_ex", 4'(stall), 4'd1);
    tick();
    ex_fire = 1; sample();
    check("t2_stall_exfire", 4'(stall), 4'd1);
    tick();
    ex_fire = 0; sample();
    check("t2_stall_me", 4'(stall), 4'd1);
    check("t2_sel2_me", 4'(fwd_sel2), 4'd2);
    tick();
    me_ld_data_ok = 1; sample();
    check("t2_stall_dok", 4'(stall), 4'd0);
    check("t2_sel2_dok", 4'(fwd_sel2), 4'd2);
    tick();
    me_ld_data_ok = 0; sample();
    check("t2_stall_latched", 4'(stall), 4'd0);
    tick();

    // T3: EX has priority over WB, and a younger load stalls despite an older ready writer
    do_reset();
    idle(); issue(5'd3, 1, 0); sample(); tick();
    idle(); ex_fire = 1; sample(); tick();
    idle(); me_fire = 1; sample(); tick();
    idle(); issue(5'd3, 1, 0); sample(); tick();
    idle(); read(5'd3, 1, 5'd3, 1); sample();
    check("t3_sel1", 4'(fwd_sel1), 4'd1);
    check("t3_sel2", 4'(fwd_sel2), 4'd1);
    check("t3_stall_alu", 4'(stall), 4'd0);
    tick();
    idle(); issue(5'd3, 1, 1); ex_fire = 1; sample(); tick();
    idle(); read(5'd3, 1, 5'd0, 0); sample();
    check("t3_stall_ld", 4'(stall), 4'd1);
    check("t3_sel1_ld", 4'(fwd_sel1), 4'd1);
    check("t3_cnt", 4'(inflight_cnt), 4'd3);
    tick();

    // T4: r0 never matches; stores do not write
    do_reset();
    idle(); issue(5'd0, 1, 1); sample(); tick();
    idle(); read(5'd0, 1, 5'd0, 1); sample();
    check("t4_sel_r0", 4'(fwd_sel1), 4'd0);
    check("t4_stall_r0", 4'(stall), 4'd0);
    tick();
    idle(); issue(5'd9, 0, 0); ex_fire = 1; sample(); tick();
    idle(); read(5'd9, 1, 5'd9, 1); sample();
    check("t4_sel_st", 4'(fwd_sel1), 4'd0);
    check("t4_stall_st", 4'(stall), 4'd0);
    tick();

    // T5: flush kills EX and ME, even with an issue in the same cycle
    do_reset();
    idle(); issue(5'd4, 1, 0); sample(); tick();
    idle(); ex_fire = 1; sample(); tick();
    idle(); me_fire = 1; sample(); tick();
    idle(); issue(5'd8, 1, 1); sample(); tick();
    idle(); issue(5'd10, 1, 0); flush = 1; sample(); tick();
    idle(); read(5'd8, 1, 5'd10, 1); sample();
    check("t5_stall", 4'(stall), 4'd0);
    check("t5_cnt", 4'(inflight_cnt), 4'd1);
    tick();

    // T6: full simultaneous shift, then reset mid-stream
    do_reset();
    idle(); issue(5'd1, 1, 0); sample(); tick();
    idle(); issue(5'd2, 1, 0); ex_fire = 1; sample(); tick();
    idle(); issue(5'd3, 1, 0); ex_fire = 1; me_fire = 1; sample(); tick();
    idle(); issue(5'd4, 1, 0); ex_fire = 1; me_fire = 1; wb_retire = 1; sample();
    check("t6_cnt_before", 4'(inflight_cnt), 4'd3);
    tick();
    idle(); read(5'd4, 1, 5'd2, 1); sample();
    check("t6_cnt_after", 4'(inflight_cnt), 4'd3);
    check("t6_sel1", 4'(fwd_sel1), 4'd1);
    check("t6_sel2", 4'(fwd_sel2), 4'd3);
    tick();
    idle(); issue(5'd6, 1, 1); ex_fire = 1; me_fire = 1; wb_retire = 1; reset = 1; tick();
    idle(); read(5'd3, 1, 5'd4, 1); sample();
    check("t6_rst_stall", 4'(stall), 4'd0);
    check("t6_rst_sel1", 4'(fwd_sel1), 4'd0);
    check("t6_rst_cnt", 4'(inflight_cnt), 4'd0);
    tick();

    // Legal random traffic with an in-order pipeline discipline
    for (int c = 0; c < 3000; c++) begin
      idle();
      reset         = ($urandom_range(0, 299) == 0);
      flush         = ($urandom_range(0, 15) == 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      id_src1       = 5'($urandom_range(0, 3));
      id_src2       = 5'($urandom_range(0, 3));
      id_src1_use   = 1'($urandom_range(0, 1));
      id_src2_use   = 1'($urandom_range(0, 1));
      id_dest       = 5'($urandom_range(0, 3));
      id_gr_we      = ($urandom_range(0, 3) != 0);
      id_is_load    = ($urandom_range(0, 2) == 0);
      me_ld_data_ok = ($urandom_range(0, 2) == 0);
      wb_retire     = 1'($urandom_range(0, 1));
      me_fire       = m[1].v && (!m[2].v || wb_retire) && ($urandom_range(0, 3) != 0);
      ex_fire       = m[0].v && (!m[1].v || me_fire) && ($urandom_range(0, 3) != 0);
      id_fire       = id_valid && !model_stall() && (!m[0].v || ex_fire) &&
                      ($urandom_range(0, 3) != 0);
      sample();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
